reg_transfer_sequencer: RTL and testbench

Sequences register-to-register moves over the shared CPU bus for the 32-bit register file.
- Arbitrates between two requesters (port 0: control unit microcode; port 1: debug/load interface) with round-robin priority.
- For the granted request, drives the one-hot Rout select so the source register reaches the bus, then pulses the destination register's Rin enable.
- Drives BAout, the R0 output gate: BAout=0 forces R0's output to zero.

---
 rtl/reg_transfer_sequencer_if.sv | 31 +++
 rtl/reg_transfer_sequencer.sv | 116 +++++++++++
 tb/tb_reg_transfer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_transfer_sequencer_if.sv
// Request/bus bundle for the register transfer sequencer.
// The master side is the requesters and bus observer; the slave side is the sequencer.
interface reg_transfer_sequencer_if #(
  parameter int NREGS = 16,
  parameter int IDX_W = 4
) ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [IDX_W-1:0] req0_src;
  logic [IDX_W-1:0] req0_dst;
  logic             req0_zero;
  logic [IDX_W-1:0] req1_src;
  logic [IDX_W-1:0] req1_dst;
  logic             req1_zero;
  logic [NREGS-1:0] Rout;
  logic [NREGS-1:0] Rin;
  logic             BAout;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output req_valid, req0_src, req0_dst, req0_zero, req1_src, req1_dst, req1_zero,
    input  req_ready, Rout, Rin, BAout, busy, done, done_id
  );

  modport slave (
    input  req_valid, req0_src, req0_dst, req0_zero, req1_src, req1_dst, req1_zero,
    output req_ready, Rout, Rin, BAout, busy, done, done_id
  );
endinterface

// File: rtl/reg_transfer_sequencer.sv
// Round-robin sequencer for register-to-register moves on the shared CPU bus:
// drives the source onto the bus for SETTLE cycles, then strobes the destination load.
module reg_transfer_sequencer #(
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4,
  parameter int SETTLE = 1
) (
  input logic                    clk,
  input logic                    clr,
  reg_transfer_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_LATCH
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_src, w_src_next;
  logic [IDX_W-1:0] r_dst, w_dst_next;
  logic             r_zero, w_zero_next;
  logic             r_last, w_last_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic             r_done, w_done_next;
  logic             r_done_id, w_done_id_next;
  logic             w_grant;
  logic [1:0]       w_ready;
  logic             w_active;
  logic [NREGS-1:0] w_rout;
  logic [NREGS-1:0] w_rin;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_zero    <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_src     <= w_src_next;
      r_dst     <= w_dst_next;
      r_zero    <= w_zero_next;
      r_last    <= w_last_next;
      r_cnt     <= w_cnt_next;
      r_done    <= w_done_next;
      r_done_id <= w_done_id_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_src_next     = r_src;
    w_dst_next     = r_dst;
    w_zero_next    = r_zero;
    w_last_next    = r_last;
    w_cnt_next     = r_cnt;
    w_done_next    = 1'b0;
    w_done_id_next = r_done_id;
    w_ready        = 2'b00;
    // With both requesting, the one not served last wins.
    w_grant = (bus.req_valid == 2'b11) ? ~r_last : bus.req_valid[1];

    case (r_state)
      S_IDLE: begin
        if (!clr && (|bus.req_valid)) begin
          w_ready[w_grant] = 1'b1;
          w_src_next       = w_grant ? bus.req1_src  : bus.req0_src;
          w_dst_next       = w_grant ? bus.req1_dst  : bus.req0_dst;
          w_zero_next      = w_grant ? bus.req1_zero : bus.req0_zero;
          w_last_next      = w_grant;
          w_cnt_next       = SETTLE_M1;
          w_state_next     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_LATCH;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_LATCH: begin
        w_state_next   = S_IDLE;
        w_done_next    = 1'b1;
        w_done_id_next = r_last;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_active = (r_state != S_IDLE);

  // One-hot decode of the captured indices onto the select and load strobes.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_onehot
    assign w_rout[gi] = w_active && (r_src == IDX_W'(gi));
    assign w_rin[gi]  = (r_state == S_LATCH) && (r_dst == IDX_W'(gi));
  end

  assign bus.Rout      = w_rout;
  assign bus.Rin       = w_rin;
  assign bus.BAout     = ~(w_active & r_zero & (r_src == '0));
  assign bus.busy      = w_active;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.req_ready = w_ready;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed plus randomized bench for reg_transfer_sequencer at SETTLE=1 and SETTLE=4,
// checked every cycle against a timeline model of each transfer.
module tb_reg_transfer_sequencer;

  logic clk;
  logic clr;

  logic [1:0] v   [2];
  logic [3:0] s0  [2];
  logic [3:0] d0  [2];
  logic       z0  [2];
  logic [3:0] s1  [2];
  logic [3:0] d1  [2];
  logic       z1  [2];

  reg_transfer_sequencer_if #(.NREGS(16), .IDX_W(4)) if1 ();
  reg_transfer_sequencer_if #(.NREGS(16), .IDX_W(4)) if4 ();

  assign if1.req_valid = v[0];
  assign if1.req0_src  = s0[0];
  assign if1.req0_dst  = d0[0];
  assign if1.req0_zero = z0[0];
  assign if1.req1_src  = s1[0];
  assign if1.req1_dst  = d1[0];
  assign if1.req1_zero = z1[0];
  assign if4.req_valid = v[1];
  assign if4.req0_src  = s0[1];
  assign if4.req0_dst  = d0[1];
  assign if4.req0_zero = z0[1];
  assign if4.req1_src  = s1[1];
  assign if4.req1_dst  = d1[1];
  assign if4.req1_zero = z1[1];

  reg_transfer_sequencer #(.NREGS(16), .IDX_W(4), .SETTLE(1)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .bus (if1.slave)
  );

  reg_transfer_sequencer #(.NREGS(16), .IDX_W(4), .SETTLE(4)) u_dut4 (
    .clk (clk),
    .clr (clr),
    .bus (if4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Timeline model: age counts cycles since accept (0 = idle); the bus is
  // driven for ages 1..S, the destination loads at age S+1, done follows.
  int         S       [2] = '{1, 4};
  int         m_age   [2] = '{0, 0};
  logic [3:0] m_src   [2] = '{4'd0, 4'd0};
  logic [3:0] m_dst   [2] = '{4'd0, 4'd0};
  logic       m_zero  [2] = '{1'b0, 1'b0};
  logic       m_id    [2] = '{1'b0, 1'b0};
  logic       m_last  [2] = '{1'b1, 1'b1};
  logic       m_dpend [2] = '{1'b0, 1'b0};
  logic       m_did   [2] = '{1'b0, 1'b0};
  logic [1:0] m_rdy   [2] = '{2'b00, 2'b00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_ready(int k);
    if (clr || m_age[k] != 0 || v[k] == 2'b00) return 2'b00;
    if (v[k] == 2'b11) return m_last[k] ? 2'b01 : 2'b10;
    return v[k];
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [1:0]  er, o_rdy;
      logic [15:0] erout, erin, o_rout, o_rin;
      logic        eba, o_ba, o_busy, o_done, o_did;
      er = exp_ready(k);
      m_rdy[k] = er;
      erout = (m_age[k] != 0) ? (16'd1 << m_src[k]) : 16'd0;
      erin  = (m_age[k] == S[k] + 1) ? (16'd1 << m_dst[k]) : 16'd0;
      eba   = !(m_age[k] != 0 && m_zero[k] && m_src[k] == 4'd0);
      if (k == 0) begin
        o_rdy = if1.req_ready; o_rout = if1.Rout; o_rin = if1.Rin; o_ba = if1.BAout;
        o_busy = if1.busy; o_done = if1.done; o_did = if1.done_id;
      end else begin
        o_rdy = if4.req_ready; o_rout = if4.Rout; o_rin = if4.Rin; o_ba = if4.BAout;
        o_busy = if4.busy; o_done = if4.done; o_did = if4.done_id;
      end
      check($sformatf("m%0d_ready", k), 32'(o_rdy), 32'(er));
      check($sformatf("m%0d_rout", k), 32'(o_rout), 32'(erout));
      check($sformatf("m%0d_rin", k), 32'(o_rin), 32'(erin));
      check($sformatf("m%0d_baout", k), 32'(o_ba), 32'(eba));
      check($sformatf("m%0d_busy", k), 32'(o_busy), 32'(m_age[k] != 0));
      check($sformatf("m%0d_done", k), 32'(o_done), 32'(m_dpend[k]));
      if (m_dpend[k]) check($sformatf("m%0d_done_id", k), 32'(o_did), 32'(m_did[k]));
    end
  endtask

  task automatic update_models();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_age[k] = 0; m_last[k] = 1'b1; m_dpend[k] = 1'b0; m_did[k] = 1'b0;
      end else begin
        m_dpend[k] = (m_age[k] == S[k] + 1);
        if (m_dpend[k]) m_did[k] = m_id[k];
        if (m_age[k] == 0) begin
          if (m_rdy[k] != 2'b00) begin
            m_id[k]   = (m_rdy[k] == 2'b10);
            m_src[k]  = m_id[k] ? s1[k] : s0[k];
            m_dst[k]  = m_id[k] ? d1[k] : d0[k];
            m_zero[k] = m_id[k] ? z1[k] : z0[k];
            m_last[k] = m_id[k];
            m_age[k]  = 1;
          end
        end else if (m_age[k] == S[k] + 1) begin
          m_age[k] = 0;
        end else begin
          m_age[k]++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_models();
    #1;
  endtask

  function automatic logic [3:0] rnd_src();
    return ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 2'b00; s0[k] = 4'd0; d0[k] = 4'd0; z0[k] = 1'b0;
      s1[k] = 4'd0; d1[k] = 4'd0; z1[k] = 1'b0;
    end
    cycle();
    cycle();
    clr = 1'b0;

    // Reset state
    check("rst_rout", 32'(if1.Rout), 32'h0);
    check("rst_rin", 32'(if1.Rin), 32'h0);
    check("rst_baout", 32'(if1.BAout), 32'h1);
    check("rst_busy", 32'(if1.busy), 32'h0);
    check("rst_done", 32'(if1.done), 32'h0);
    check("rst_ready", 32'(if1.req_ready), 32'h0);

    // Single transfer 3->7
    v[0] = 2'b01; s0[0] = 4'd3; d0[0] = 4'd7; z0[0] = 1'b0;
    #1 check("t1_ready", 32'(if1.req_ready), 32'h1);
    cycle();
    v[0] = 2'b00;
    check("t1_drive_rout", 32'(if1.Rout), 32'h0008);
    check("t1_drive_rin", 32'(if1.Rin), 32'h0);
    check("t1_drive_baout", 32'(if1.BAout), 32'h1);
    cycle();
    check("t1_latch_rout", 32'(if1.Rout), 32'h0008);
    check("t1_latch_rin", 32'(if1.Rin), 32'h0080);
    cycle();
    check("t1_done", 32'(if1.done), 32'h1);
    check("t1_done_id", 32'(if1.done_id), 32'h0);
    check("t1_idle_rout", 32'(if1.Rout), 32'h0);

    // R0 read as zero, then the same move without the zero request
    v[0] = 2'b10; s1[0] = 4'd0; d1[0] = 4'd5; z1[0] = 1'b1;
    cycle();
    v[0] = 2'b00;
    check("t2_drive_rout", 32'(if1.Rout), 32'h0001);
    check("t2_drive_baout", 32'(if1.BAout), 32'h0);
    cycle();
    check("t2_latch_rin", 32'(if1.Rin), 32'h0020);
    check("t2_latch_baout", 32'(if1.BAout), 32'h0);
    cycle();
    check("t2_idle_baout", 32'(if1.BAout), 32'h1);
    check("t2_done_id", 32'(if1.done_id), 32'h1);
    v[0] = 2'b10; z1[0] = 1'b0;
    cycle();
    v[0] = 2'b00;
    check("t2b_drive_baout", 32'(if1.BAout), 32'h1);
    cycle();
    cycle();

    // Round robin with both requesters continuously valid
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    v[0] = 2'b11; s0[0] = 4'd1; d0[0] = 4'd2; s1[0] = 4'd4; d1[0] = 4'd6;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i % 3 == 0) check($sformatf("t3_grant%0d", i / 3), 32'(if1.req_ready), ((i / 3) % 2 == 0) ? 32'h1 : 32'h2);
      cycle();
    end
    v[0] = 2'b00;
    #1;
    check("t3_last_done", 32'(if1.done), 32'h1);
    check("t3_last_done_id", 32'(if1.done_id), 32'h1);
    cycle();

    // SETTLE=4 instance, 2->9
    v[1] = 2'b01; s0[1] = 4'd2; d0[1] = 4'd9; z0[1] = 1'b0;
    #1 check("t4_ready", 32'(if4.req_ready), 32'h1);
    cycle();
    v[1] = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_drive%0d_rout", i), 32'(if4.Rout), 32'h0004);
      check($sformatf("t4_drive%0d_rin", i), 32'(if4.Rin), 32'h0);
      cycle();
    end
    check("t4_latch_rin", 32'(if4.Rin), 32'h0200);
    cycle();
    check("t4_done", 32'(if4.done), 32'h1);
    cycle();

    // clr during DRIVE drops the transfer and restores priority to requester 0
    v[0] = 2'b01; s0[0] = 4'd3; d0[0] = 4'd7;
    cycle();
    v[0] = 2'b00;
    check("t5_drive_rout", 32'(if1.Rout), 32'h0008);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("t5_rout", 32'(if1.Rout), 32'h0);
    check("t5_rin", 32'(if1.Rin), 32'h0);
    check("t5_busy", 32'(if1.busy), 32'h0);
    check("t5_done", 32'(if1.done), 32'h0);
    check("t5_baout", 32'(if1.BAout), 32'h1);
    v[0] = 2'b11; d0[0] = 4'd8;
    #1 check("t5_ready", 32'(if1.req_ready), 32'h1);
    cycle();
    v[0] = 2'b00;
    cycle();
    cycle();
    cycle();

    // Requester 1 raises then drops valid while requester 0 is served
    v[0] = 2'b01; s0[0] = 4'd5; d0[0] = 4'd6;
    cycle();
    v[0] = 2'b10; s1[0] = 4'd1; d1[0] = 4'd2;
    cycle();
    v[0] = 2'b00;
    cycle();
    check("t6_ready", 32'(if1.req_ready), 32'h0);
    check("t6_done_id", 32'(if1.done_id), 32'h0);
    cycle();
    check("t6_busy", 32'(if1.busy), 32'h0);

    // Randomized traffic on both instances
    for (int n = 0; n < 800; n++) begin
      clr = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) begin
          logic [3:0] ns, nd;
          logic       nz;
          ns = rnd_src();
          nd = 4'($urandom_range(0, 15));
          nz = 1'($urandom_range(0, 1));
          if (v[k][j] && m_rdy[k][j]) begin
            v[k][j] = ($urandom_range(0, 1) == 1);
          end else if (v[k][j]) begin
            if ($urandom_range(0, 9) == 0) v[k][j] = 1'b0;
            continue;
          end else begin
            v[k][j] = ($urandom_range(0, 2) == 0);
          end
          if (j == 0) begin
            s0[k] = ns; d0[k] = nd; z0[k] = nz;
          end else begin
            s1[k] = ns; d1[k] = nd; z1[k] = nz;
          end
        end
      end
      cycle();
    end
    clr = 1'b0;
    v[0] = 2'b00;
    v[1] = 2'b00;
    for (int n = 0; n < 8; n++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
